// File: rtl/add_seq_wide.sv
// Multi-cycle wide adder: one 16-bit carry-lookahead slice is reused for each
// 16-bit word of the operands, LSW first, with the inter-slice carry held in a register.

module cla_16bits (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] s,
    output logic        pm,
    output logic        gm
);
    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] c;
    logic [3:0]  gp;
    logic [3:0]  gg;
    logic [3:0]  gc;

    always_comb begin
        p = a ^ b;
        g = a & b;
    end

    // Group propagate/generate for each 4-bit nibble.
    always_comb begin
        gp = '0;
        gg = '0;
        for (int k = 0; k < 4; k++) begin
            gp[k] = &p[4*k +: 4];
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
    end

    always_comb begin
        gc[0] = c_in;
        gc[1] = gg[0] | (gp[0] & c_in);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_in);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & c_in);
        pm    = &gp;
        gm    = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0]);
    end

    // Bit carries inside each nibble, looked ahead from the nibble carry-in.
    always_comb begin
        c = '0;
        for (int k = 0; k < 4; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end
        s = p ^ c;
    end
endmodule

module add_seq_wide #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [16*WORDS-1:0] a,
    input  logic [16*WORDS-1:0] b,
    input  logic                cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [16*WORDS-1:0] sum,
    output logic                cout,
    output logic                overflow
);
    localparam int W     = 16 * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic             carry;
    logic [IDX_W-1:0] idx;
    logic [15:0]      slice_a;
    logic [15:0]      slice_b;
    logic [15:0]      slice_s;
    logic             pm;
    logic             gm;
    logic             c_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (idx == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Mux the current word of each registered operand into the shared slice.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (idx == IDX_W'(w)) begin
                slice_a = a_reg[16*w +: 16];
                slice_b = b_reg[16*w +: 16];
            end
        end
    end

    cla_16bits u_cla (
        .a    (slice_a),
        .b    (slice_b),
        .c_in (carry),
        .s    (slice_s),
        .pm   (pm),
        .gm   (gm)
    );

    assign c_next = gm | (pm & carry);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        carry    <= cin;
                        idx      <= '0;
                        sum      <= '0;
                        cout     <= 1'b0;
                        overflow <= 1'b0;
                    end
                end
                RUN: begin
                    for (int w = 0; w < WORDS; w++) begin
                        if (idx == IDX_W'(w)) begin
                            sum[16*w +: 16] <= slice_s;
                        end
                    end
                    carry <= c_next;
                    // The top word's sum MSB is only available here, so the flags are latched now.
                    if (idx == LAST) begin
                        cout     <= c_next;
                        overflow <= (a_reg[W-1] == b_reg[W-1]) && (slice_s[15] != a_reg[W-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_add_seq_wide.sv
// Self-checking bench for add_seq_wide (WORDS=4): directed vector table, handshake
// and reset corner sequences, and random operands against a 65-bit reference sum.

module tb_add_seq_wide;
    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;
    localparam int CW    = W + 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    add_seq_wide #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    task automatic check_output(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Issue one operation from a negedge and return the result once out_valid rises.
    task automatic apply_stimulus(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                                  input logic op_cin, input int ready_delay,
                                  output logic [W-1:0] got_sum, output logic got_cout,
                                  output logic got_ovf, output int lat);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        a        = op_a;
        b        = op_b;
        cin      = op_cin;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_output("accept_wait", CW'(in_ready), CW'(1'b1));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = {$urandom, $urandom};
        b        = {$urandom, $urandom};
        cin      = 1'($urandom_range(0, 1));
        lat      = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            check_output("result_wait", CW'(out_valid), CW'(1'b1));
        end
        got_sum  = sum;
        got_cout = cout;
        got_ovf  = overflow;
        repeat (ready_delay) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [W-1:0] gs;
        logic         gc;
        logic         go;
        int           lat;
        logic [W:0]   ref_full;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic         rovf;

        vecs[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};
        vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
        vecs[4] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'h2468_ACF1_3579_BDE0, 1'b0, 1'b0};
        vecs[5] = '{64'h0, 64'h0, 1'b1, 64'h1, 1'b0, 1'b0};
        vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        vecs[7] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 64'h0001_0000_0001_0000, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_output("reset_in_ready",  CW'(in_ready),  CW'(1'b1));
        check_output("reset_out_valid", CW'(out_valid), CW'(1'b0));
        check_output("reset_sum",       CW'(sum),       CW'(0));
        check_output("reset_cout",      CW'(cout),      CW'(1'b0));
        check_output("reset_overflow",  CW'(overflow),  CW'(1'b0));

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].cin, i % 3, gs, gc, go, lat);
            check_output($sformatf("vec%0d_sum", i),  CW'(gs),  CW'(vecs[i].sum));
            check_output($sformatf("vec%0d_cout", i), CW'(gc),  CW'(vecs[i].cout));
            check_output($sformatf("vec%0d_ovf", i),  CW'(go),  CW'(vecs[i].ovf));
            check_output($sformatf("vec%0d_latency", i), CW'(lat), CW'(5));
        end

        // Backpressure: result held for 10 cycles while a stray request is offered.
        in_valid = 1'b1;
        a        = 64'h1;
        b        = 64'h2;
        cin      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_output("bp_valid_start", CW'(out_valid), CW'(1'b1));
        for (int k = 0; k < 10; k++) begin
            in_valid = (k == 3);
            a        = 64'hDEAD_BEEF_0000_0001;
            b        = 64'h5;
            @(negedge clk);
            check_output("bp_out_valid", CW'(out_valid), CW'(1'b1));
            check_output("bp_in_ready",  CW'(in_ready),  CW'(1'b0));
            check_output("bp_sum",       CW'({cout, overflow, sum}), CW'({1'b0, 1'b0, 64'h3}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_output("bp_release_in_ready",  CW'(in_ready),  CW'(1'b1));
        check_output("bp_release_out_valid", CW'(out_valid), CW'(1'b0));
        check_output("bp_release_sum_held",  CW'(sum),       CW'(64'h3));
        repeat (6) @(negedge clk);
        check_output("bp_pulse_dropped", CW'(out_valid), CW'(1'b0));

        // Reset during the second RUN cycle, after slice 0 has been written.
        in_valid = 1'b1;
        a        = 64'hFFFF_FFFF_FFFF_FFFF;
        b        = 64'hFFFF_FFFF_FFFF_FFFF;
        cin      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("rst_run_in_ready",  CW'(in_ready),  CW'(1'b1));
        check_output("rst_run_out_valid", CW'(out_valid), CW'(1'b0));
        check_output("rst_run_outputs",   CW'({cout, overflow, sum}), CW'(0));
        repeat (6) @(negedge clk);
        check_output("rst_run_no_result", CW'(out_valid), CW'(1'b0));
        apply_stimulus(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 0, gs, gc, go, lat);
        check_output("post_rst_result", CW'({gc, go, gs}), CW'({1'b0, 1'b0, 64'h2468_ACF1_3579_BDE0}));

        // Reset while a result with cout=1 and overflow=1 is waiting in DONE.
        in_valid = 1'b1;
        a        = 64'h8000_0000_0000_0000;
        b        = 64'h8000_0000_0000_0000;
        cin      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check_output("rst_done_flags_set", CW'({out_valid, cout, overflow}), CW'(3'b111));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("rst_done_outputs", CW'({in_ready, out_valid, cout, overflow, sum}), CW'({1'b1, 1'b0, 1'b0, 1'b0, 64'h0}));

        for (int n = 0; n < 3000; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) ra = '1;
            if ($urandom_range(0, 7) == 0) rb = {1'b0, {(W-1){1'b1}}};
            rc = 1'($urandom_range(0, 1));
            ref_full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            rovf     = (ra[W-1] == rb[W-1]) && (ref_full[W-1] != ra[W-1]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            apply_stimulus(ra, rb, rc, $urandom_range(0, 3), gs, gc, go, lat);
            check_output($sformatf("rand%0d", n), CW'({gc, go, gs}), CW'({ref_full[W], rovf, ref_full[W-1:0]}));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
